uart_cmd_decoder: RTL and testbench

Parametrised command/data decoder for the 40 MHz UART receive path. It unloads bytes from the UART receiver and classifies each byte as data, trigger command, RAM select or control-register address. It produces single-cycle strobes toward the control-register banks, the LUT RAMs and the trigger consumers. It generalises the fixed-function decoder with a parametrised trigger count, RAM address width and skip pattern, plus three new features: control-register auto-increment, sticky RAM overflow protection and a command-error strobe.

---
 rtl/uart_cmd_decoder_if.sv | 20 ++
 rtl/uart_cmd_decoder.sv | 131 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Byte handshake between the UART receiver and the command decoder.
// master: UART receiver side (drives data_in/byte_rdy, sees byte_uld).
// slave:  decoder side (samples data_in/byte_rdy, drives byte_uld).
interface uart_cmd_decoder_if;
    logic [7:0] data_in;   // received byte, stable while byte_rdy or byte_uld is high
    logic       byte_rdy;  // UART has a byte available
    logic       byte_uld;  // unload acknowledge back to the UART

    modport master (
        output data_in,
        output byte_rdy,
        input  byte_uld
    );

    modport slave (
        input  data_in,
        input  byte_rdy,
        output byte_uld
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Purpose: classify UART bytes into data / trigger / RAM select / ctrl-address and emit write strobes.
// Latency: strobes and trig pulse one cycle after the decode cycle (byte_rdy low, byte_uld high).
// Backpressure: none; byte_uld holds the UART until it drops byte_rdy, at most one byte per 3 cycles.
//
// Ports: clk, rst (sync, active-high); uart (slave: data_in, byte_rdy, byte_uld);
//   current_addr/data_out/data_strobe to the control-register banks;
//   ram_select/ram_addr/ram_data/ram_data_strobe/ram_overflow to the LUT RAMs;
//   trig (one-hot pulses) to trigger consumers; cmd_error pulse on undefined commands.
// Optional feature: define UART_DECODER_AUTOINC_EN to enable 0x0C/0x0D
//   control-register auto-increment; when undefined those bytes pulse cmd_error.
module uart_cmd_decoder #(
    parameter int          NUM_TRIG   = 9,
    parameter int          NUM_RAMS   = 5,
    parameter int          RAM_ADDR_W = 15,
    parameter logic [31:0] SKIP_MASK  = 32'h0000_0003,
    parameter int          SKIP_RUN   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_cmd_decoder_if.slave      uart,
    output logic [6:0]             current_addr,
    output logic [6:0]             data_out,
    output logic                   data_strobe,
    output logic [4:0]             ram_select,
    output logic [RAM_ADDR_W-1:0]  ram_addr,
    output logic [6:0]             ram_data,
    output logic                   ram_data_strobe,
    output logic [NUM_TRIG-1:0]    trig,
    output logic                   ram_overflow,
    output logic                   cmd_error
);

    // Skip counter only has to reach SKIP_RUN-1; on non-skip RAMs it may wrap freely.
    localparam int SKW = (SKIP_RUN > 1) ? $clog2(SKIP_RUN) : 1;

    typedef enum logic {CTRL, FILL_RAM} state_t;

    state_t          state;
    logic [SKW-1:0]  skip_cnt;
`ifdef UART_DECODER_AUTOINC_EN
    logic            autoinc;
`endif

    logic            skip_now;
    logic [RAM_ADDR_W:0] addr_next;   // one extra bit catches the overflow carry
    logic [7:0]      din;

    assign din       = uart.data_in;
    assign skip_now  = SKIP_MASK[ram_select] && (skip_cnt == SKW'(SKIP_RUN - 1));
    assign addr_next = {1'b0, ram_addr} + (skip_now ? (RAM_ADDR_W+1)'(2) : (RAM_ADDR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= CTRL;
            uart.byte_uld   <= 1'b0;
            current_addr    <= '0;
            data_out        <= '0;
            data_strobe     <= 1'b0;
            ram_select      <= '0;
            ram_addr        <= '0;
            ram_data        <= '0;
            ram_data_strobe <= 1'b0;
            trig            <= '0;
            ram_overflow    <= 1'b0;
            cmd_error       <= 1'b0;
            skip_cnt        <= '0;
`ifdef UART_DECODER_AUTOINC_EN
            autoinc         <= 1'b0;
`endif
        end else begin
            data_strobe     <= 1'b0;
            ram_data_strobe <= 1'b0;
            trig            <= '0;
            cmd_error       <= 1'b0;

            // Address advance after a RAM write; saturate and latch overflow at the top.
            if (ram_data_strobe) begin
                if (addr_next[RAM_ADDR_W]) begin
                    ram_addr     <= '1;
                    ram_overflow <= 1'b1;
                end else begin
                    ram_addr <= addr_next[RAM_ADDR_W-1:0];
                end
                skip_cnt <= skip_now ? '0 : skip_cnt + 1'b1;
            end

`ifdef UART_DECODER_AUTOINC_EN
            // Bit 6 selects the register bank and is never carried into.
            if (data_strobe && autoinc)
                current_addr[5:0] <= current_addr[5:0] + 6'd1;
`endif

            // Handshake: hold byte_uld while the UART keeps byte_rdy; decode when it lets go.
            // The 3-cycle byte spacing keeps decode away from the address updates above.
            if (uart.byte_rdy) begin
                uart.byte_uld <= 1'b1;
            end else if (uart.byte_uld) begin
                uart.byte_uld <= 1'b0;
                if (din[7]) begin
                    if (state == CTRL) begin
                        data_out    <= din[6:0];
                        data_strobe <= 1'b1;
                    end else if (!ram_overflow) begin
                        ram_data        <= din[6:0];
                        ram_data_strobe <= 1'b1;
                    end
                end else if (32'(din) < NUM_TRIG) begin
                    trig <= NUM_TRIG'(1) << din[3:0];
`ifdef UART_DECODER_AUTOINC_EN
                end else if (din == 8'h0C) begin
                    autoinc <= 1'b0;
                end else if (din == 8'h0D) begin
                    autoinc <= 1'b1;
`endif
                end else if (din[6:5] == 2'b01 && 32'(din[4:0]) < NUM_RAMS) begin
                    state        <= FILL_RAM;
                    ram_select   <= din[4:0];
                    ram_addr     <= '0;
                    skip_cnt     <= '0;
                    ram_overflow <= 1'b0;
                end else if (din[6]) begin
                    state        <= CTRL;
                    current_addr <= din[6:0];
                end else begin
                    cmd_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: a default-parameter instance plus a RAM_ADDR_W=3
// instance share one byte stream; a reference model of the decoder rules
// predicts every strobe-cycle and post-strobe output.
module tb_uart_cmd_decoder;

    localparam int          T_NUM_TRIG  = 9;
    localparam int          T_NUM_RAMS  = 5;
    localparam logic [31:0] T_SKIP_MASK = 32'h0000_0003;
    localparam int          T_SKIP_RUN  = 3;
`ifdef UART_DECODER_AUTOINC_EN
    localparam bit T_AUTOINC = 1'b1;
`else
    localparam bit T_AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic [7:0] din;

    always #5 clk = ~clk;

    uart_cmd_decoder_if u0 ();
    uart_cmd_decoder_if u1 ();
    assign u0.data_in  = din;
    assign u0.byte_rdy = rdy;
    assign u1.data_in  = din;
    assign u1.byte_rdy = rdy;

    logic [6:0]  o0_cur, o0_dout, o0_rdat, o1_cur, o1_dout, o1_rdat;
    logic        o0_ds, o0_rs, o0_ovf, o0_err, o1_ds, o1_rs, o1_ovf, o1_err;
    logic [4:0]  o0_sel, o1_sel;
    logic [14:0] o0_raddr;
    logic [2:0]  o1_raddr;
    logic [8:0]  o0_trig, o1_trig;

    uart_cmd_decoder #(.NUM_TRIG(T_NUM_TRIG), .NUM_RAMS(T_NUM_RAMS), .RAM_ADDR_W(15),
                       .SKIP_MASK(T_SKIP_MASK), .SKIP_RUN(T_SKIP_RUN)) dut0 (
        .clk(clk), .rst(rst), .uart(u0.slave),
        .current_addr(o0_cur), .data_out(o0_dout), .data_strobe(o0_ds),
        .ram_select(o0_sel), .ram_addr(o0_raddr), .ram_data(o0_rdat),
        .ram_data_strobe(o0_rs), .trig(o0_trig), .ram_overflow(o0_ovf), .cmd_error(o0_err));

    uart_cmd_decoder #(.NUM_TRIG(T_NUM_TRIG), .NUM_RAMS(T_NUM_RAMS), .RAM_ADDR_W(3),
                       .SKIP_MASK(T_SKIP_MASK), .SKIP_RUN(T_SKIP_RUN)) dut1 (
        .clk(clk), .rst(rst), .uart(u1.slave),
        .current_addr(o1_cur), .data_out(o1_dout), .data_strobe(o1_ds),
        .ram_select(o1_sel), .ram_addr(o1_raddr), .ram_data(o1_rdat),
        .ram_data_strobe(o1_rs), .trig(o1_trig), .ram_overflow(o1_ovf), .cmd_error(o1_err));

    int checks = 0;
    int errors = 0;
    int cur_byte = 0;

    // Reference model: RAM address is a pure function of the write count since select.
    int m_ctrl, m_cur, m_dout, m_rsel, m_auto;
    int m_rdata[2], m_n[2], m_max[2];
    int waddr0[$];
    int wcur[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (byte %0h): observed=%0h expected=%0h", tag, cur_byte, obs, exp);
        end
    endtask

    function automatic int addr_of(input int n);
        return T_SKIP_MASK[m_rsel] ? n + n / T_SKIP_RUN : n;
    endfunction

    function automatic int disp_addr(input int i);
        int a = addr_of(m_n[i]);
        return (a > m_max[i]) ? m_max[i] : a;
    endfunction

    function automatic int is_ovf(input int i);
        return (addr_of(m_n[i]) > m_max[i]) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_ctrl = 1; m_cur = 0; m_dout = 0; m_rsel = 0; m_auto = 0;
        m_rdata = '{0, 0}; m_n = '{0, 0};
    endtask

    task automatic check_reset_outputs();
        chk("rst_uld0",  u0.byte_uld, 0);  chk("rst_uld1",  u1.byte_uld, 0);
        chk("rst_strb0", {o0_ds, o0_rs, o0_err, o0_trig}, 0);
        chk("rst_strb1", {o1_ds, o1_rs, o1_err, o1_trig}, 0);
        chk("rst_cur0",  o0_cur, 0);    chk("rst_dout0", o0_dout, 0);
        chk("rst_rdat0", o0_rdat, 0);   chk("rst_sel0",  o0_sel, 0);
        chk("rst_radr0", o0_raddr, 0);  chk("rst_ovf0",  o0_ovf, 0);
        chk("rst_radr1", o1_raddr, 0);  chk("rst_ovf1",  o1_ovf, 0);
    endtask

    // Called at a negedge; returns at the negedge after the strobe has cleared.
    task automatic send_byte(input logic [7:0] b);
        bit got;
        int e_ds, e_trig, e_err;
        int e_rs[2];
        cur_byte = b;
        din = b;
        rdy = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = u0.byte_uld;
        end
        chk("uld_rise0", got, 1);
        chk("uld_rise1", u1.byte_uld, 1);
        rdy = 1'b0;

        e_ds = 0; e_trig = 0; e_err = 0; e_rs = '{0, 0};
        if (b >= 128) begin
            if (m_ctrl == 1) begin
                e_ds = 1; m_dout = b - 128;
            end else begin
                for (int i = 0; i < 2; i++)
                    if (addr_of(m_n[i]) <= m_max[i]) begin
                        e_rs[i] = 1; m_rdata[i] = b - 128;
                    end
            end
        end else if (b < T_NUM_TRIG) begin
            e_trig = 1 << b;
        end else if (T_AUTOINC && (b == 12 || b == 13)) begin
            m_auto = (b == 13) ? 1 : 0;
        end else if (b >= 32 && b < 32 + T_NUM_RAMS) begin
            m_ctrl = 0; m_rsel = b - 32; m_n = '{0, 0};
        end else if (b >= 64) begin
            m_ctrl = 1; m_cur = b;
        end else begin
            e_err = 1;
        end

        @(negedge clk);   // strobe cycle
        chk("uld_fall", u0.byte_uld, 0);
        chk("dstrb",  o0_ds, e_ds);
        chk("rstrb0", o0_rs, e_rs[0]);
        chk("rstrb1", o1_rs, e_rs[1]);
        chk("trig",   o0_trig, e_trig);
        chk("cmderr", o0_err, e_err);
        chk("cur",    o0_cur, m_cur);
        chk("dout",   o0_dout, m_dout);
        chk("rsel",   o0_sel, m_rsel);
        chk("radr0",  o0_raddr, disp_addr(0));
        chk("radr1",  o1_raddr, disp_addr(1));
        chk("rdat0",  o0_rdat, m_rdata[0]);
        chk("rdat1",  o1_rdat, m_rdata[1]);
        chk("ovf0",   o0_ovf, is_ovf(0));
        chk("ovf1",   o1_ovf, is_ovf(1));
        if (o0_rs) waddr0.push_back(int'(o0_raddr));
        if (o0_ds) wcur.push_back(int'(o0_cur));

        for (int i = 0; i < 2; i++) if (e_rs[i] == 1) m_n[i]++;
        if (e_ds == 1 && m_auto == 1) m_cur = (m_cur & 64) | ((m_cur + 1) & 63);

        @(negedge clk);   // strobe cleared, addresses advanced
        chk("strb_clr0", {o0_ds, o0_rs, o0_err, o0_trig}, 0);
        chk("strb_clr1", {o1_ds, o1_rs, o1_err, o1_trig}, 0);
        chk("cur_post",  o0_cur, m_cur);
        chk("radr0_post", o0_raddr, disp_addr(0));
        chk("radr1_post", o1_raddr, disp_addr(1));
        chk("ovf0_post", o0_ovf, is_ovf(0));
        chk("ovf1_post", o1_ovf, is_ovf(1));
    endtask

    int exp_skip[8] = '{0, 1, 2, 4, 5, 6, 8, 9};
    int exp_inc[3];

    initial begin
        m_max = '{32767, 7};
        model_reset();
        rst = 1'b1; rdy = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Address then data in CTRL mode
        send_byte(8'h45);
        send_byte(8'h92);
        chk("dir_cur45", o0_cur, 7'h45);
        chk("dir_dout12", o0_dout, 7'h12);

        // Skip-pattern RAM
        waddr0.delete();
        send_byte(8'h20);
        for (int i = 0; i < 8; i++) send_byte(8'h80 | 8'(i * 5));
        chk("skip_cnt", waddr0.size(), 8);
        for (int i = 0; i < 8 && i < waddr0.size(); i++) chk("skip_addr", waddr0[i], exp_skip[i]);

        // Linear RAM with overflow on the 3-bit instance
        waddr0.delete();
        send_byte(8'h22);
        for (int i = 0; i < 10; i++) send_byte(8'h80 | 8'(i + 1));
        chk("lin_cnt", waddr0.size(), 10);
        chk("dir_ovf1", o1_ovf, 1);
        send_byte(8'h22);
        chk("dir_ovf1_clr", o1_ovf, 0);
        chk("dir_radr1_clr", o1_raddr, 0);

        // Triggers
        for (int i = 0; i < T_NUM_TRIG; i++) send_byte(8'(i));

        // Auto-increment
        wcur.delete();
        send_byte(8'h0D);
        send_byte(8'h7E);
        for (int i = 0; i < 3; i++) send_byte(8'h81 + 8'(i));
        if (T_AUTOINC) exp_inc = '{'h7E, 'h7F, 'h40};
        else           exp_inc = '{'h7E, 'h7E, 'h7E};
        chk("inc_cnt", wcur.size(), 3);
        for (int i = 0; i < 3 && i < wcur.size(); i++) chk("inc_addr", wcur[i], exp_inc[i]);
        send_byte(8'h0C);

        // Undefined commands
        send_byte(8'h15);
        send_byte(8'h3F);

        // Randomized stream
        for (int i = 0; i < 200; i++) begin
            int c;
            logic [7:0] b;
            c = $urandom_range(0, 9);
            case (c)
                0, 1, 2, 3, 4: b = 8'h80 | 8'($urandom_range(0, 127));
                5:             b = 8'($urandom_range(0, 15));
                6:             b = 8'h20 + 8'($urandom_range(0, 6));
                7:             b = 8'h40 + 8'($urandom_range(0, 63));
                8:             b = 8'($urandom_range(0, 127));
                default:       b = 8'h0C + 8'($urandom_range(0, 1));
            endcase
            send_byte(b);
        end

        // Put some non-reset state in place, then reset mid-handshake
        send_byte(8'h21);
        send_byte(8'hAA);
        cur_byte = 8'h55;
        din = 8'h55; rdy = 1'b1;
        @(negedge clk);
        chk("mid_uld", u0.byte_uld, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        send_byte(8'h92);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
